// File: rtl/sram_arb_pkg.sv
// +-----------------------------------------------------------------------+
// | sram_arb_pkg : shared state encoding and default sizes for sram_arb    |
// | Revision     : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package sram_arb_pkg;

  localparam int c_addr_w_def = 14;
  localparam int c_data_w_def = 32;
  localparam int c_tmo_w_def  = 20;

  typedef enum logic [1:0] {
    ST_FUNC  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BIST  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_arb_rr.sv
// +-----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter, last winner yields on a tie     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set after requester 0 wins, so requester 1 takes the next tie.
  logic r_prio_b;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !r_prio_b)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b0;
    end else if (gnt[0]) begin
      r_prio_b <= 1'b1;
    end else if (gnt[1]) begin
      r_prio_b <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arb.sv
// +-----------------------------------------------------------------------+
// | sram_arb : two functional ports plus exclusive BIST access to one SRAM |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_def,
  parameter int DATA_W = c_data_w_def,
  parameter int TMO_W  = c_tmo_w_def
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  input  logic                bist_req,
  output logic                bist_gnt,
  input  logic                bist_cen,
  input  logic [DATA_W/8-1:0] bist_wen,
  input  logic [ADDR_W-1:0]   bist_addr,
  input  logic [DATA_W-1:0]   bist_wdata,
  input  logic                bist_done,
  input  logic                bist_fail,
  output logic                test_done,
  output logic                test_fail,
  output logic                test_tmo,
  output logic                mem_cen,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  localparam int c_nb = DATA_W / 8;
  // Last count before terminal; the watchdog fires on the 2^TMO_W-1'th BIST cycle.
  localparam logic [TMO_W-1:0] c_wdog_last = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        w_arb_req;
  logic [1:0]        w_gnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              r_test_done;
  logic              r_test_fail;
  logic              r_test_tmo;
  logic [TMO_W-1:0]  r_wdog;

  // A pending BIST request blocks functional grants in the same cycle.
  assign w_arb_req = (r_state == ST_FUNC && !bist_req) ? {b_req, a_req} : 2'b00;

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (w_arb_req),
    .gnt (w_gnt)
  );

  assign a_gnt     = w_gnt[0];
  assign b_gnt     = w_gnt[1];
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rvalid ? mem_dout : '0;
  assign b_rdata   = r_b_rvalid ? mem_dout : '0;
  assign test_done = r_test_done;
  assign test_fail = r_test_fail;
  assign test_tmo  = r_test_tmo;

  always_comb begin
    w_state_nxt = r_state;
    bist_gnt    = 1'b0;
    mem_cen     = 1'b1;
    mem_wen     = {c_nb{1'b1}};
    mem_addr    = '0;
    mem_din     = '0;
    case (r_state)
      ST_FUNC: begin
        if (bist_req) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_gnt[0]) begin
          mem_cen  = 1'b0;
          mem_wen  = a_we ? ~a_be : {c_nb{1'b1}};
          mem_addr = a_addr;
          mem_din  = a_wdata;
        end else if (w_gnt[1]) begin
          mem_cen  = 1'b0;
          mem_wen  = b_we ? ~b_be : {c_nb{1'b1}};
          mem_addr = b_addr;
          mem_din  = b_wdata;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_BIST;
      end
      ST_BIST: begin
        bist_gnt = 1'b1;
        mem_cen  = bist_cen;
        mem_wen  = bist_wen;
        mem_addr = bist_addr;
        mem_din  = bist_wdata;
        if (!bist_req) begin
          w_state_nxt = ST_FUNC;
        end
      end
      default: begin
        w_state_nxt = ST_FUNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FUNC;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_test_done <= 1'b0;
      r_test_fail <= 1'b0;
      r_test_tmo  <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_rvalid <= w_gnt[0] & ~a_we;
      r_b_rvalid <= w_gnt[1] & ~b_we;
      if (r_state == ST_FUNC && bist_req) begin
        r_test_done <= 1'b0;
        r_test_fail <= 1'b0;
        r_test_tmo  <= 1'b0;
        r_wdog      <= '0;
      end else if (r_state == ST_BIST && !r_test_done) begin
        // The first completion wins; status is then frozen until the next drain.
        if (bist_done) begin
          r_test_done <= 1'b1;
          r_test_fail <= bist_fail;
        end else if (r_wdog == c_wdog_last) begin
          r_test_done <= 1'b1;
          r_test_fail <= 1'b1;
          r_test_tmo  <= 1'b1;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arb.sv
// +-----------------------------------------------------------------------+
// | tb_sram_arb : directed and random checks of sram_arb vs a cycle model  |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_sram_arb;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int TW = 4;
  localparam int TMO_CYC = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [NB-1:0] a_be;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [NB-1:0] b_be;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          bist_req, bist_gnt, bist_cen, bist_done, bist_fail;
  logic [NB-1:0] bist_wen;
  logic [AW-1:0] bist_addr;
  logic [DW-1:0] bist_wdata;
  logic          test_done, test_fail, test_tmo;
  logic          mem_cen;
  logic [NB-1:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  sram_arb #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bist_req(bist_req), .bist_gnt(bist_gnt), .bist_cen(bist_cen), .bist_wen(bist_wen),
    .bist_addr(bist_addr), .bist_wdata(bist_wdata), .bist_done(bist_done), .bist_fail(bist_fail),
    .test_done(test_done), .test_fail(test_fail), .test_tmo(test_tmo),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Small SRAM behind the arbiter; cleared while reset is held.
  logic [DW-1:0] sram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram[i] <= '0;
    end else if (!mem_cen) begin
      for (int i = 0; i < NB; i++)
        if (!mem_wen[i]) sram[mem_addr[5:0]][i*8 +: 8] <= mem_din[i*8 +: 8];
      mem_dout <= sram[mem_addr[5:0]];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=functional, 1=drain, 2=BIST.
  int            m_mode = 0;
  bit            m_fav_b = 1'b0;
  bit            m_arv = 1'b0, m_brv = 1'b0;
  logic [DW-1:0] m_ard, m_brd;
  bit            m_done = 1'b0, m_fail = 1'b0, m_tmo = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] ref_mem [64];
  bit            chk_en = 1'b0;
  bit            a_taken = 1'b0, b_taken = 1'b0;
  bit            ea, eb;
  logic          e_cen;
  logic [NB-1:0] e_wen;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  always @(negedge clk) begin
    if (chk_en) begin
      ea = 1'b0;
      eb = 1'b0;
      if (m_mode == 0 && !bist_req) begin
        if (a_req && b_req) begin
          ea = !m_fav_b;
          eb = m_fav_b;
        end else begin
          ea = a_req;
          eb = b_req;
        end
      end
      e_cen = 1'b1; e_wen = '1; e_addr = '0; e_din = '0;
      if (m_mode == 2) begin
        e_cen = bist_cen; e_wen = bist_wen; e_addr = bist_addr; e_din = bist_wdata;
      end else if (ea) begin
        e_cen = 1'b0; e_wen = a_we ? ~a_be : '1; e_addr = a_addr; e_din = a_wdata;
      end else if (eb) begin
        e_cen = 1'b0; e_wen = b_we ? ~b_be : '1; e_addr = b_addr; e_din = b_wdata;
      end
      check_val("a_gnt", a_gnt, ea);
      check_val("b_gnt", b_gnt, eb);
      check_val("bist_gnt", bist_gnt, m_mode == 2);
      check_val("mem_cen", mem_cen, e_cen);
      check_val("mem_wen", mem_wen, e_wen);
      check_val("mem_addr", mem_addr, e_addr);
      check_val("mem_din", mem_din, e_din);
      check_val("a_rvalid", a_rvalid, m_arv);
      check_val("b_rvalid", b_rvalid, m_brv);
      if (m_arv) check_val("a_rdata", a_rdata, m_ard);
      if (m_brv) check_val("b_rdata", b_rdata, m_brd);
      check_val("test_done", test_done, m_done);
      check_val("test_fail", test_fail, m_fail);
      check_val("test_tmo", test_tmo, m_tmo);
      a_taken = a_gnt;
      b_taken = b_gnt;

      if (rst) begin
        m_mode = 0; m_fav_b = 1'b0; m_arv = 1'b0; m_brv = 1'b0;
        m_done = 1'b0; m_fail = 1'b0; m_tmo = 1'b0; m_cnt = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      end else begin
        m_arv = ea && !a_we;
        m_brv = eb && !b_we;
        if (m_arv) m_ard = ref_mem[a_addr[5:0]];
        if (m_brv) m_brd = ref_mem[b_addr[5:0]];
        for (int i = 0; i < NB; i++) begin
          if (ea && a_we && a_be[i]) ref_mem[a_addr[5:0]][i*8 +: 8] = a_wdata[i*8 +: 8];
          if (eb && b_we && b_be[i]) ref_mem[b_addr[5:0]][i*8 +: 8] = b_wdata[i*8 +: 8];
        end
        if (ea) m_fav_b = 1'b1;
        else if (eb) m_fav_b = 1'b0;
        case (m_mode)
          0: if (bist_req) begin
               m_mode = 1; m_done = 1'b0; m_fail = 1'b0; m_tmo = 1'b0; m_cnt = 0;
             end
          1: m_mode = 2;
          default: begin
            if (!m_done) begin
              if (bist_done) begin
                m_done = 1'b1; m_fail = bist_fail;
              end else begin
                m_cnt++;
                if (m_cnt == TMO_CYC) begin
                  m_done = 1'b1; m_fail = 1'b1; m_tmo = 1'b1;
                end
              end
            end
            if (!bist_req) m_mode = 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_taken) a_req = 1'b0;
    if (b_taken) b_req = 1'b0;
  endtask

  int na, nb, bist_hold;

  initial begin
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    bist_req = 0; bist_cen = 1; bist_wen = '1; bist_addr = '0; bist_wdata = '0;
    bist_done = 0; bist_fail = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_cen", mem_cen, 1);
    check_val("rst_wen", mem_wen, 4'hF);
    check_val("rst_bist_gnt", bist_gnt, 0);
    check_val("rst_done", test_done, 0);

    // A read and B write to the same word, requested together.
    tick();
    a_req = 1; a_we = 0; a_addr = 14'h10; a_be = 4'hF;
    b_req = 1; b_we = 1; b_addr = 14'h10; b_be = 4'hF; b_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_val("r22_a_first", a_gnt, 1);
    check_val("r22_b_wait", b_gnt, 0);
    tick();
    @(negedge clk);
    check_val("r22_a_rvalid", a_rvalid, 1);
    check_val("r22_b_gnt", b_gnt, 1);
    tick(); tick();
    a_req = 1; a_we = 0; a_addr = 14'h10;
    tick();
    @(negedge clk);
    check_val("r22_rdata", a_rdata, 32'hDEADBEEF);

    // Continuous contention alternates.
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      a_req = 1; a_we = 0; a_addr = AW'(i);
      b_req = 1; b_we = 0; b_addr = AW'(i + 1);
      @(negedge clk);
      na += int'(a_gnt); nb += int'(b_gnt);
    end
    check_val("r23_a_cnt", na, 4);
    check_val("r23_b_cnt", nb, 4);
    tick(); tick(); tick();

    // Partial byte write.
    a_req = 1; a_we = 1; a_be = 4'b0101; a_addr = 14'h5; a_wdata = 32'h11223344;
    @(negedge clk);
    check_val("r24_wen", mem_wen, 4'b1010);

    // BIST entry with a colliding functional request, then completion.
    tick();
    a_req = 1; a_we = 0; a_addr = 14'h5; bist_req = 1;
    @(negedge clk);
    check_val("r25_no_agnt", a_gnt, 0);
    tick();
    @(negedge clk);
    check_val("r25_drain_cen", mem_cen, 1);
    check_val("r25_drain_bgnt", bist_gnt, 0);
    tick();
    bist_done = 1; bist_fail = 0;
    @(negedge clk);
    check_val("r25_bist_gnt", bist_gnt, 1);
    tick();
    bist_done = 1; bist_fail = 1;
    @(negedge clk);
    check_val("r25_done", test_done, 1);
    check_val("r25_fail", test_fail, 0);
    tick();
    bist_done = 0;
    @(negedge clk);
    check_val("r25_fail_held", test_fail, 0);
    bist_req = 0;
    tick();
    @(negedge clk);
    check_val("r25_func_agnt", a_gnt, 1);

    // Watchdog expiry.
    tick();
    bist_req = 1;
    tick(); tick();
    for (int i = 0; i < TMO_CYC - 1; i++) tick();
    @(negedge clk);
    check_val("r26_tmo_early", test_tmo, 0);
    tick();
    @(negedge clk);
    check_val("r26_done", test_done, 1);
    check_val("r26_fail", test_fail, 1);
    check_val("r26_tmo", test_tmo, 1);
    bist_req = 0; a_req = 1; a_we = 0; a_addr = 14'h7;
    tick();
    @(negedge clk);
    check_val("r26_agnt", a_gnt, 1);

    // Reset in the middle of BIST.
    tick();
    bist_req = 1;
    tick(); tick();
    bist_done = 1; bist_fail = 1;
    tick();
    bist_done = 0;
    @(negedge clk);
    check_val("r27_pre_done", test_done, 1);
    rst = 1; bist_req = 0;
    tick();
    rst = 0;
    @(negedge clk);
    check_val("r27_bist_gnt", bist_gnt, 0);
    check_val("r27_done", test_done, 0);
    check_val("r27_fail", test_fail, 0);

    // Random traffic against the model.
    bist_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!a_req && ($urandom % 3 == 0)) begin
        a_req = 1; a_we = 1'($urandom); a_be = 4'($urandom);
        a_addr = AW'($urandom % 64); a_wdata = $urandom;
      end
      if (!b_req && ($urandom % 3 == 0)) begin
        b_req = 1; b_we = 1'($urandom); b_be = 4'($urandom);
        b_addr = AW'($urandom % 64); b_wdata = $urandom;
      end
      if (bist_hold > 0) begin
        bist_hold--;
        bist_req = 1;
      end else begin
        bist_req = 0;
        if ($urandom % 25 == 0) bist_hold = int'($urandom_range(2, 25));
      end
      bist_cen   = 1'($urandom);
      bist_addr  = AW'($urandom % 64);
      bist_wdata = $urandom;
      bist_done  = ($urandom % 10 == 0);
      bist_fail  = 1'($urandom);
      rst        = ($urandom % 150 == 0);
    end
    tick();
    rst = 0;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
